// File: rtl/fpu_special_pkg.sv
// Shared encodings and constants for the FPU special-operand detector.
// Op codes, cause bit indices and width-parametrised NaN and saturation words.
package fpu_special_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_MUL  = 3'b010,
    OP_DIV  = 3'b011,
    OP_TRIG = 3'b100,
    OP_SQRT = 3'b101,
    OP_RSV0 = 3'b110,
    OP_RSV1 = 3'b111
  } op_e;

  localparam int CAUSE_W    = 3;
  localparam int CAUSE_INV  = 0;
  localparam int CAUSE_NAN  = 1;
  localparam int CAUSE_SNAN = 2;

  // Exponent all-ones plus fraction MSB, sign 0.
  function automatic logic [63:0] canon_qnan(int ew, int sw);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++)
      if (i >= sw - 1 && i < sw + ew) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [63:0] cnt_max(int cw);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++)
      if (i < cw) r[i] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/fpu_special_if.sv
// Operand/result handshake bundle of the special-case detector.
// master drives operands and out_ready; slave is the detector.
import fpu_special_pkg::*;

interface fpu_special_if #(
  parameter int W = 32
) ();
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         op;
  logic [W-1:0]       data1;
  logic [W-1:0]       data2;
  logic               out_valid;
  logic               out_ready;
  logic               nan_flag;
  logic [CAUSE_W-1:0] cause;
  logic [W-1:0]       nan_result;

  modport master (
    output in_valid, op, data1, data2, out_ready,
    input  in_ready, out_valid, nan_flag, cause, nan_result
  );

  modport slave (
    input  in_valid, op, data1, data2, out_ready,
    output in_ready, out_valid, nan_flag, cause, nan_result
  );
endinterface

// File: rtl/fpu_operand_classify.sv
// Combinational IEEE-754 operand classifier.
// Reports sign, zero, infinity, NaN and signalling NaN.
import fpu_special_pkg::*;

module fpu_operand_classify #(
  parameter int EW = 8,
  parameter int SW = 23
) (
  input  logic [EW+SW:0] x,
  output logic           sign,
  output logic           is_zero,
  output logic           is_inf,
  output logic           is_nan,
  output logic           is_snan
);
  logic [EW-1:0] expo;
  logic [SW-1:0] frac;
  logic          e_max;
  logic          f_zero;

  assign sign    = x[EW+SW];
  assign expo    = x[EW+SW-1:SW];
  assign frac    = x[SW-1:0];
  assign e_max   = &expo;
  assign f_zero  = ~|frac;
  assign is_zero = ~|expo & f_zero;
  assign is_inf  = e_max & f_zero;
  assign is_nan  = e_max & ~f_zero;
  assign is_snan = is_nan & ~frac[SW-1];
endmodule

// File: rtl/fpu_special_case_pipe.sv
// Two-stage special-operand / invalid-op detector with sticky status.
// FPU_SNAN_DETECT_EN: signalling-NaN operands raise cause[2] and invalid.
import fpu_special_pkg::*;

module fpu_special_case_pipe #(
  parameter int W     = 32,
  parameter int EW    = 8,
  parameter int SW    = 23,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  fpu_special_if.slave     bus,
  input  logic             clr_sticky,
  output logic             invalid_sticky,
  output logic [CNT_W-1:0] nan_count
);
  localparam logic [63:0] QNAN64 = canon_qnan(EW, SW);
  localparam logic [W-1:0] QNAN = QNAN64[W-1:0];
  localparam logic [63:0] CMAX64 = cnt_max(CNT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = CMAX64[CNT_W-1:0];

  logic [1:0] sg, zr, nf, nn, sn;

  fpu_operand_classify #(.EW(EW), .SW(SW)) u_cls_a (
    .x(bus.data1), .sign(sg[0]), .is_zero(zr[0]),
    .is_inf(nf[0]), .is_nan(nn[0]), .is_snan(sn[0])
  );

  fpu_operand_classify #(.EW(EW), .SW(SW)) u_cls_b (
    .x(bus.data2), .sign(sg[1]), .is_zero(zr[1]),
    .is_inf(nf[1]), .is_nan(nn[1]), .is_snan(sn[1])
  );

  logic               v1, v2;
  op_e                op1;
  logic [W-1:0]       a1, b1;
  logic [1:0]         sg1, zr1, nf1, nn1, sn1;
  logic               flag2;
  logic [CAUSE_W-1:0] cause2;
  logic [W-1:0]       res2;

  logic en1, en2, acc;
  assign en2 = ~v2 | bus.out_ready;
  assign en1 = ~v1 | en2;
  assign acc = v2 & bus.out_ready;

  assign bus.in_ready   = en1 & ~rst;
  assign bus.out_valid  = v2;
  assign bus.nan_flag   = flag2;
  assign bus.cause      = cause2;
  assign bus.nan_result = res2;

  logic               use_b, rsv, nan_in, snan_in;
  logic               both_inf, sgn_eq, inv;
  logic [CAUSE_W-1:0] cause_d;
  logic               flag_d;
  logic [W-1:0]       quiet, res_d;

  always_comb begin
    use_b    = ~op1[2];
    rsv      = op1[2] & op1[1];
    nan_in   = ~rsv & (nn1[0] | (use_b & nn1[1]));
    snan_in  = ~rsv & (sn1[0] | (use_b & sn1[1]));
    both_inf = nf1[0] & nf1[1];
    sgn_eq   = sg1[0] == sg1[1];
    inv      = 1'b0;
    unique case (1'b1)
      op1 == OP_ADD:  inv = both_inf & ~sgn_eq;
      op1 == OP_SUB:  inv = both_inf & sgn_eq;
      op1 == OP_MUL:  inv = (zr1[0] & nf1[1]) | (nf1[0] & zr1[1]);
      op1 == OP_DIV:  inv = (zr1[0] & zr1[1]) | both_inf;
      op1 == OP_TRIG: inv = nf1[0];
      op1 == OP_SQRT: inv = sg1[0] & ~zr1[0];
      default:        inv = 1'b0;
    endcase
    cause_d = '0;
    cause_d[CAUSE_NAN] = nan_in;
`ifdef FPU_SNAN_DETECT_EN
    cause_d[CAUSE_INV]  = (inv & ~nan_in) | snan_in;
    cause_d[CAUSE_SNAN] = snan_in;
`else
    cause_d[CAUSE_INV]  = inv & ~nan_in;
`endif
    flag_d = cause_d[CAUSE_INV] | cause_d[CAUSE_NAN];
    quiet  = nn1[0] ? a1 : b1;
    quiet[SW-1] = 1'b1;
    if (nan_in)      res_d = quiet;
    else if (flag_d) res_d = QNAN;
    else             res_d = '0;
  end

`ifndef FPU_SNAN_DETECT_EN
  logic snan_unused;
  assign snan_unused = snan_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      v1             <= 1'b0;
      v2             <= 1'b0;
      op1            <= OP_ADD;
      a1             <= '0;
      b1             <= '0;
      sg1            <= '0;
      zr1            <= '0;
      nf1            <= '0;
      nn1            <= '0;
      sn1            <= '0;
      flag2          <= 1'b0;
      cause2         <= '0;
      res2           <= '0;
      invalid_sticky <= 1'b0;
      nan_count      <= '0;
    end else begin
      if (en1) begin
        v1 <= bus.in_valid;
        if (bus.in_valid) begin
          op1 <= op_e'(bus.op);
          a1  <= bus.data1;
          b1  <= bus.data2;
          sg1 <= sg;
          zr1 <= zr;
          nf1 <= nf;
          nn1 <= nn;
          sn1 <= sn;
        end
      end
      if (en2) begin
        v2     <= v1;
        flag2  <= v1 & flag_d;
        cause2 <= v1 ? cause_d : '0;
        res2   <= v1 ? res_d : '0;
      end
      // A clear coinciding with a qualifying accept keeps the new event.
      if (clr_sticky) begin
        invalid_sticky <= acc & cause2[CAUSE_INV];
        nan_count      <= (acc & flag2) ? CNT_W'(1) : '0;
      end else if (acc) begin
        invalid_sticky <= invalid_sticky | cause2[CAUSE_INV];
        if (flag2 && nan_count != CNT_MAX)
          nan_count <= nan_count + 1'b1;
      end
    end
  end
endmodule

// File: doc/fpu_special_case_pipe.md
Name: fpu_special_case_pipe

Overview:
- Parametrised, pipelined special-operand / invalid-operation detector for the FPU and CORDIC datapaths.
- Sits beside each arithmetic unit and sees the same operands, with a valid/ready handshake.
- Flags IEEE-754 invalid operations and NaN inputs, and produces the NaN result word.
- Keeps a sticky invalid flag and a saturating NaN event counter for the status register.

Parameters:
- W, 32: operand width (32 or 64).
- EW, 8: exponent width (11 when W=64).
- SW, 23: fraction width (52 when W=64); W = 1+EW+SW.
- CNT_W, 8: width of nan_count.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operands valid
- in_ready  out  1  block accepts operands this cycle
- op  in  3  000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 TRIG (CORDIC), 101 SQRT, 11x reserved
- data1  in  W  operand A
- data2  in  W  operand B (ignored for TRIG/SQRT)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- nan_flag  out  1  result is NaN
- cause  out  3  bit0 invalid-op, bit1 NaN input propagated, bit2 signalling-NaN input
- nan_result  out  W  NaN word to substitute when nan_flag=1
- clr_sticky  in  1  clear invalid_sticky and nan_count
- invalid_sticky  out  1  sticky OR of accepted cause[0]
- nan_count  out  CNT_W  saturating count of accepted results with nan_flag=1

Behaviour:
- Classification per operand:
  - zero: exponent=0 and fraction=0.
  - inf: exponent all-ones and fraction=0.
  - NaN: exponent all-ones and fraction≠0.
  - sNaN: NaN with fraction MSB=0.
- Invalid-op (cause[0]), evaluated only when neither used operand is NaN:
  - ADD: both inf, signs differ.
  - SUB: both inf, signs equal.
  - MUL: (zero,inf) or (inf,zero), any signs.
  - DIV: (zero,zero) or (inf,inf).
  - TRIG: data1 inf.
  - SQRT: data1 sign=1 and not zero (so -0 gives no flag; -inf flags).
  - Reserved ops: all cause bits 0, nan_flag 0.
- NaN input (cause[1]): any used operand is NaN.
- nan_flag = cause[0] | cause[1].
- nan_result:
  - NaN input present: data1's NaN if data1 is NaN, else data2's, quieted (fraction MSB forced to 1).
  - Otherwise: canonical qNaN = sign 0, exponent all-ones, fraction MSB 1, rest 0 (0x7FC00000 for W=32).
  - nan_flag=0: nan_result = 0.
- Pipeline: two register stages (S1 classify, S2 decide); latency exactly 2 cycles with no stalls.
  - en2 = !v2 | out_ready; en1 = !v1 | en2; in_ready = en1 & !rst.
  - Transfer on in_valid&in_ready; output accepted on out_valid&out_ready.
  - Bubbles collapse; full throughput of 1 result/cycle while out_ready=1.
  - Output data held stable while out_valid&!out_ready.
- Sticky/counter: update on an accepted output only.
  - invalid_sticky sets when accepted cause[0]=1.
  - nan_count increments when accepted nan_flag=1 and saturates at all-ones.
  - clr_sticky with a simultaneous qualifying accept: result is sticky=1, count=1 (the new event is kept).
- Reset: all pipeline valids, out_valid, nan_flag, cause, nan_result, invalid_sticky and nan_count go to 0; in_ready is 0 while rst=1. In-flight operations are discarded.

Optional Feature:
- FPU_SNAN_DETECT_EN defined: a sNaN operand sets cause[2] and also cause[0] (IEEE invalid), so it reaches invalid_sticky.
- Undefined: sNaN is treated as qNaN, cause[2] is tied 0, and NaN inputs never set cause[0].

Decomposition:
- Package fpu_special_pkg: op encodings, cause bit indices, CNT saturation constant, canonical-qNaN constant/function parametrised by EW/SW.
- Sub-module fpu_operand_classify: combinational; outputs sign, is_zero, is_inf, is_nan, is_snan. Instantiated twice in S1.

Test Plan:
- W=32, ADD 0x7F800000 + 0xFF800000 -> 2 cycles later out_valid=1, nan_flag=1, cause=001, nan_result=0x7FC00000, invalid_sticky=1, nan_count=1.
- ADD 0x7F800000 + 0x7F800000 -> nan_flag=0. SUB with the same operands -> cause=001.
- MUL 0x80000000 × 0x7F800000 -> cause=001. SQRT 0x80000000 -> nan_flag=0. SQRT 0xBF800000 -> cause=001.
- ADD 0x7FA00001 + 0x3F800000 -> nan_result=0x7FE00001, cause bit1=1; bit2 and bit0 =1 only with FPU_SNAN_DETECT_EN.
- Back-to-back 4 ops with out_ready held 0 for 3 cycles:
  - in_ready drops after 2 accepted ops.
  - Outputs stay stable, no op is lost, order is preserved.
  - Asserting clr_sticky together with an accepted invalid result leaves sticky=1, count=1.
- W=64 (EW=11, SW=52), DIV 0×0 -> nan_result=0x7FF8000000000000. 300 invalid ops give nan_count=255 (saturation). rst mid-stream gives out_valid=0 the next cycle.
